interval_timer: RTL and testbench
=================================

INTERVAL_TIMER -- requirements
Module: interval_timer

Interface
REQ-001 Parameter DIV, default 100, meaning clock cycles per timer second; legal range 2..65535.
REQ-002 Port clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port Reset_n  input  1  reset, asynchronous and active-low (one clock domain only).
REQ-004 Port start_timer  input  1  restart request from the controller FSM; sampled on rising clk.
REQ-005 Port value  input  4  interval length in seconds, driven by TimeParameter; sampled only on the edge where start_timer=1.
REQ-006 Port expired  output  1  one-cycle pulse, interval finished.
REQ-007 Port busy  output  1  high while an interval is counting.
REQ-008 Port remaining  output  4  seconds left in current interval.

Function
REQ-009 The block SHALL implement states IDLE, COUNT and DONE; expired=1 only in DONE, busy=1 only in COUNT, both registered (Moore).
REQ-010 The block SHALL contain a prescaler of width ceil(log2(DIV)) counting 0..DIV-1 and wrapping to 0.
REQ-011 On an edge with start_timer=1 and value>0, from any state: remaining<=value, prescaler<=0, state<=COUNT.
REQ-012 On an edge with start_timer=1 and value=0, from any state: remaining<=0, prescaler<=0, state<=DONE (expired high the next cycle).
REQ-013 In COUNT without start_timer, the prescaler SHALL increment each cycle; at prescaler=DIV-1 it SHALL wrap to 0 and remaining SHALL decrement by 1 (a tick).
REQ-014 A tick with remaining=1 SHALL set remaining<=0 and state<=DONE.
REQ-015 Latency: for start at edge N with value V>0, expired SHALL be high exactly between edges N+V*DIV and N+V*DIV+1.
REQ-016 DONE SHALL last one cycle, then state<=IDLE unless start_timer=1 on that edge (REQ-011/012 apply).
REQ-017 In IDLE without start_timer, remaining and prescaler SHALL hold.
REQ-018 start_timer SHALL take priority over a same-cycle tick; a restart during COUNT discards the old interval without asserting expired.
REQ-019 start_timer held high SHALL reload every cycle; counting begins on the first cycle it is low.
REQ-020 remaining SHALL never wrap below 0 or exceed 15.

Reset
REQ-021 Reset_n=0 SHALL immediately (no clock) force state=IDLE, remaining=0, prescaler=0, expired=0, busy=0.
REQ-022 Reset_n released mid-interval SHALL leave the block in IDLE; no expired pulse until a new start_timer.
REQ-023 Deassertion of Reset_n SHALL be synchronised by the system; the block takes effect on the first rising clk with Reset_n=1.

Verification (DIV=4)
REQ-024 value=3, start_timer pulse at edge N -> busy=1 from N; remaining 3,2,1 changing at N+4, N+8; expired high N+12..N+13 only; busy=0 from N+12.
REQ-025 value=0, start pulse at edge N -> busy stays 0; expired high N..N+1; state IDLE afterward.
REQ-026 value=15 start -> expired exactly 60 cycles after start edge; remaining sequence 15..0 with no wrap.
REQ-027 value=5 start, second start with value=2 at edge N+6 -> no expired near N+20; expired high N+14..N+15.
REQ-028 value=4 start, Reset_n low for 3 cycles mid-count -> outputs zero asynchronously; no expired afterward until a new start.
REQ-029 start_timer held high 5 cycles with value=1 -> busy=1 throughout; expired exactly 4 cycles after the last high edge.

Source files
------------

// File: rtl/interval_timer.sv
// Interval timer: counts a 4-bit number of "seconds" of DIV clock cycles each.
// It pulses expired for one cycle when the interval ends and reports busy/remaining meanwhile.
module interval_timer #(
    parameter int DIV = 100
) (
    input  logic       clk,
    input  logic       Reset_n,
    input  logic       start_timer,
    input  logic [3:0] value,
    output logic       expired,
    output logic       busy,
    output logic [3:0] remaining
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    rem_q, rem_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          expired_q, busy_q;

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            rem_q     <= 4'd0;
            pre_q     <= '0;
            expired_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            pre_q     <= pre_d;
            expired_q <= (state_d == DONE);
            busy_q    <= (state_d == COUNT);
        end
    end

    // A restart always wins over a tick in the same cycle.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        pre_d   = pre_q;
        if (start_timer) begin
            pre_d = '0;
            rem_d = value;
            if (value != 4'd0) begin
                state_d = COUNT;
            end else begin
                state_d = DONE;
            end
        end else begin
            case (state_q)
                COUNT: begin
                    if (pre_q == PRE_MAX) begin
                        pre_d = '0;
                        if (rem_q <= 4'd1) begin
                            rem_d   = 4'd0;
                            state_d = DONE;
                        end else begin
                            rem_d = rem_q - 4'd1;
                        end
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    assign expired   = expired_q;
    assign busy      = busy_q;
    assign remaining = rem_q;

endmodule

// File: tb/tb_interval_timer.sv
// Bench for interval_timer (DIV=4): directed scenarios plus random restarts,
// checked against a deadline-arithmetic model of the interval.
module tb_interval_timer;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       start_timer = 1'b0;
    logic [3:0] value = 4'd0;
    logic       expired, busy;
    logic [3:0] remaining;

    int n_total = 0;
    int n_pass  = 0;

    // Model: an interval is described by its start edge and length only.
    int         t = 0;
    int         st_edge = 0;
    int         st_val = 0;
    bit         live = 0;
    logic       e_exp, e_busy;
    logic [3:0] e_rem;

    interval_timer #(.DIV(DIV)) dut (
        .clk        (clk),
        .Reset_n    (Reset_n),
        .start_timer(start_timer),
        .value      (value),
        .expired    (expired),
        .busy       (busy),
        .remaining  (remaining)
    );

    always #5 clk = ~clk;

    function automatic void model_eval();
        int el;
        e_exp  = 1'b0;
        e_busy = 1'b0;
        e_rem  = 4'd0;
        if (live) begin
            el = t - st_edge;
            if (el < st_val * DIV) begin
                e_busy = 1'b1;
                e_rem  = 4'(st_val - el / DIV);
            end else if (el == st_val * DIV) begin
                e_exp = 1'b1;
            end
        end
    endfunction

    task automatic tick(input logic s, input logic [3:0] v);
        start_timer = s;
        value       = v;
        @(posedge clk);
        t++;
        if (!Reset_n) begin
            live = 0;
        end else if (s) begin
            live    = 1;
            st_edge = t;
            st_val  = int'(v);
        end
        model_eval();
        #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        live = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 4'd7);
            n_total++;
            if ({busy, expired, remaining} !== 6'd0) begin
                $display("FAIL reset_hold: got busy=%b expired=%b rem=%0d, want all zero", busy, expired, remaining);
            end else n_pass++;
        end
        Reset_n = 1'b1;
        tick(1'b0, 4'd0);
        n_total++;
        if ({busy, expired, remaining} !== 6'd0) begin
            $display("FAIL reset_release: got busy=%b expired=%b rem=%0d, want idle zeros", busy, expired, remaining);
        end else n_pass++;
    endtask

    task automatic test_basic();
        tick(1'b1, 4'd3);
        n_total++;
        if (busy !== 1'b1 || remaining !== 4'd3 || expired !== 1'b0) begin
            $display("FAIL basic_start: got busy=%b rem=%0d exp=%b, want 1/3/0", busy, remaining, expired);
        end else n_pass++;
        for (int k = 1; k <= 14; k++) begin
            tick(1'b0, 4'd0);
            n_total++;
            if ({busy, expired, remaining} !== {e_busy, e_exp, e_rem}) begin
                $display("FAIL basic_k%0d: got busy=%b exp=%b rem=%0d, want %b/%b/%0d", k, busy, expired, remaining, e_busy, e_exp, e_rem);
            end else n_pass++;
            if (k == 4 || k == 8 || k == 12) begin
                n_total++;
                if (remaining !== 4'(3 - k / 4)) begin
                    $display("FAIL basic_rem_k%0d: got %0d want %0d", k, remaining, 3 - k / 4);
                end else n_pass++;
            end
            if (k == 12 || k == 13) begin
                n_total++;
                if (expired !== (k == 12) || busy !== 1'b0) begin
                    $display("FAIL basic_expire_k%0d: got exp=%b busy=%b want exp=%b busy=0", k, expired, busy, k == 12);
                end else n_pass++;
            end
        end
    endtask

    task automatic test_zero();
        tick(1'b1, 4'd0);
        n_total++;
        if (expired !== 1'b1 || busy !== 1'b0 || remaining !== 4'd0) begin
            $display("FAIL zero_start: got exp=%b busy=%b rem=%0d want 1/0/0", expired, busy, remaining);
        end else n_pass++;
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 4'd0);
            n_total++;
            if (expired !== 1'b0 || busy !== 1'b0) begin
                $display("FAIL zero_after%0d: got exp=%b busy=%b want 0/0", k, expired, busy);
            end else n_pass++;
        end
    endtask

    task automatic test_max();
        int seen = -1;
        tick(1'b1, 4'd15);
        for (int k = 1; k <= 80 && seen < 0; k++) begin
            tick(1'b0, 4'd0);
            n_total++;
            if ({busy, expired, remaining} !== {e_busy, e_exp, e_rem}) begin
                $display("FAIL max_k%0d: got busy=%b exp=%b rem=%0d, want %b/%b/%0d", k, busy, expired, remaining, e_busy, e_exp, e_rem);
            end else n_pass++;
            if (expired === 1'b1) seen = k;
        end
        n_total++;
        if (seen != 15 * DIV) begin
            $display("FAIL max_latency: got %0d cycles want %0d", seen, 15 * DIV);
        end else n_pass++;
        tick(1'b0, 4'd0);
    endtask

    task automatic test_restart();
        int nexp = 0;
        int at = -1;
        tick(1'b1, 4'd5);
        for (int k = 1; k <= 24; k++) begin
            tick(k == 6, 4'd2);
            n_total++;
            if ({busy, expired, remaining} !== {e_busy, e_exp, e_rem}) begin
                $display("FAIL restart_k%0d: got busy=%b exp=%b rem=%0d, want %b/%b/%0d", k, busy, expired, remaining, e_busy, e_exp, e_rem);
            end else n_pass++;
            if (expired === 1'b1) begin
                nexp++;
                at = k;
            end
        end
        n_total++;
        if (nexp != 1 || at != 14) begin
            $display("FAIL restart_expire: got %0d pulses last at %0d want 1 at 14", nexp, at);
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 4'd4);
        for (int k = 0; k < 6; k++) tick(1'b0, 4'd0);
        #2;
        Reset_n = 1'b0;
        live = 0;
        model_eval();
        #1;
        n_total++;
        if ({busy, expired, remaining} !== 6'd0) begin
            $display("FAIL reset_async: got busy=%b exp=%b rem=%0d want zeros", busy, expired, remaining);
        end else n_pass++;
        for (int k = 0; k < 3; k++) tick(1'b0, 4'd0);
        Reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick(1'b0, 4'd0);
            n_total++;
            if ({busy, expired, remaining} !== 6'd0) begin
                $display("FAIL reset_mid_after%0d: got busy=%b exp=%b rem=%0d want zeros", k, busy, expired, remaining);
            end else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int seen = -1;
        for (int k = 0; k < 5; k++) begin
            tick(1'b1, 4'd1);
            n_total++;
            if (busy !== 1'b1 || remaining !== 4'd1 || expired !== 1'b0) begin
                $display("FAIL hold_k%0d: got busy=%b rem=%0d exp=%b want 1/1/0", k, busy, remaining, expired);
            end else n_pass++;
        end
        for (int k = 1; k <= 10 && seen < 0; k++) begin
            tick(1'b0, 4'd0);
            if (expired === 1'b1) seen = k;
        end
        n_total++;
        if (seen != DIV) begin
            $display("FAIL hold_latency: got %0d want %0d", seen, DIV);
        end else n_pass++;
        tick(1'b0, 4'd0);
    endtask

    task automatic test_random();
        logic       s;
        logic [3:0] v;
        for (int k = 0; k < 600; k++) begin
            s = ($urandom_range(0, 15) == 0);
            v = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            tick(s, v);
            n_total++;
            if ({busy, expired, remaining} !== {e_busy, e_exp, e_rem}) begin
                $display("FAIL random_k%0d: got busy=%b exp=%b rem=%0d, want %b/%b/%0d", k, busy, expired, remaining, e_busy, e_exp, e_rem);
            end else n_pass++;
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_zero();
        test_max();
        test_restart();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
